// File: rtl/divmod2_sched_pkg.sv
// Shared definitions for the divide-by-power-of-two scheduler: FSM state
// encoding and the shift-count clamp helper.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Shift counts larger than the operand width behave exactly like a full-width shift.
    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned w);
        return (k > w) ? w : k;
    endfunction

endpackage

// File: rtl/divmod2_sched_step.sv
// Single combinational halving step: one bit of shift per use, sequenced by
// the scheduler so only one copy exists.
module divmod2_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] div2_o,
    output logic         mod2_o
);

    assign div2_o = a_i >> 1;
    assign mod2_o = a_i[0];

endmodule

// File: rtl/divmod2_sched.sv
// Round-robin scheduler sharing one halving step between NREQ requesters;
// returns Q = A >> K and R = A mod 2^K after min(K,W) iterations.
module divmod2_sched
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int KW   = 4,
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    a_in,
    input  logic [NREQ*KW-1:0]   k_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         q,
    output logic [W-1:0]         r
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [W-1:0]      work_q, work_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     kk_q, kk_d;

    logic [2*NREQ-1:0] reqDouble;
    logic [NREQ-1:0]   reqRotated;
    logic              found;
    int                offset;
    logic [IDW-1:0]    winner;
    logic [W-1:0]      aSel;
    logic [KW-1:0]     kSel;
    logic [KW-1:0]     kClamped;
    logic [W-1:0]      stepDiv2;
    logic              stepMod2;

    divmod2_step #(.W(W)) u_step (
        .a_i    (work_q),
        .div2_o (stepDiv2),
        .mod2_o (stepMod2)
    );

    // Rotate the request vector so bit 0 is the requester just after the last winner.
    always_comb begin
        reqDouble  = {req, req};
        reqRotated = NREQ'(reqDouble >> (int'(rr_q) + 1));
        found      = |reqRotated;
        offset     = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (reqRotated[j]) begin
                offset = j;
            end
        end
        winner   = IDW'((int'(rr_q) + 1 + offset) % NREQ);
        aSel     = a_in[winner*W +: W];
        kSel     = k_in[winner*KW +: KW];
        kClamped = KW'(clamp_k(32'(kSel), W));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = (kClamped == '0) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (cnt_q == kk_q - KW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_DONE);
        if ((state_q == S_IDLE) && found && reset) begin
            gnt = NREQ'(1) << winner;
        end
    end

    // Each STEP cycle shifts one bit out of work and deposits it into rem at position cnt.
    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        kk_d   = kk_q;
        id_d   = id_q;
        rr_d   = rr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    work_d = aSel;
                    kk_d   = kClamped;
                    rem_d  = '0;
                    cnt_d  = '0;
                    id_d   = winner;
                    rr_d   = winner;
                end
            end
            S_STEP: begin
                work_d = stepDiv2;
                rem_d  = rem_q | (W'(stepMod2) << cnt_q);
                cnt_d  = cnt_q + KW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            kk_q   <= '0;
            id_q   <= '0;
            rr_q   <= '0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            kk_q   <= kk_d;
            id_q   <= id_d;
            rr_q   <= rr_d;
        end
    end

    assign q       = work_q;
    assign r       = rem_q;
    assign resp_id = id_q;

endmodule
